clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_meas_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 37 +++
 rtl/clk_period_meter.sv | 125 ++++++++++++
 tb/tb_clk_period_meter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg
// Shared definitions for the clock period meter:
//   meas_state_t - measurement FSM state encoding (IDLE / ARM / MEASURE)
//   SYNC_STAGES  - depth of the iSig metastability synchronizer
package clk_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } meas_state_t;

   localparam int SYNC_STAGES = 2;

endpackage : clk_meas_pkg

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous level into the clk_i domain through a
// SYNC_STAGES-deep flop chain, then compares it against one history flop to
// produce single-cycle rise/fall events.
// Ports:
//   clk_i  - system clock (rising edge)
//   rst_ni - asynchronous active-low reset, clears every flop
//   sig_i  - asynchronous input level
//   rise   - one-cycle pulse after a synchronized 0->1 transition
//   fall   - one-cycle pulse after a synchronized 1->0 transition
module sync_edge_det
   import clk_meas_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule : sync_edge_det

// File: rtl/clk_period_meter.sv
// clk_period_meter
// Measures the period and high time of a slow, asynchronous clock-like
// signal in units of iClk cycles. Measurements run back to back: the rise
// that closes one period opens the next.
// Ports:
//   iClk     - system clock (rising edge)
//   iRst     - asynchronous active-low reset
//   iEn      - measurement enable; low aborts and parks the FSM in IDLE
//   iSig     - signal under measurement (asynchronous)
//   ovPeriod - last measured period, iClk cycles
//   ovHigh   - last measured high time, iClk cycles
//   oValid   - one-cycle pulse when ovPeriod/ovHigh update
//   oTimeout - sticky: no rise arrived before the period counter saturated
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_BITS = 16
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEn,
   input  logic                iSig,
   output logic [CNT_BITS-1:0] ovPeriod,
   output logic [CNT_BITS-1:0] ovHigh,
   output logic                oValid,
   output logic                oTimeout
);

   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic rise;
   logic fall;

   sync_edge_det u_sync_edge_det (
      .clk_i  (iClk),
      .rst_ni (iRst),
      .sig_i  (iSig),
      .rise   (rise),
      .fall   (fall)
   );

   meas_state_t         state_q;
   logic [CNT_BITS-1:0] pcnt_q;
   logic [CNT_BITS-1:0] hcnt_q;
   logic [CNT_BITS-1:0] hold_high_q;
   logic                fall_seen_q;
   logic [CNT_BITS-1:0] period_q;
   logic [CNT_BITS-1:0] high_q;
   logic                valid_q;
   logic                timeout_q;

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q     <= ST_IDLE;
         pcnt_q      <= '0;
         hcnt_q      <= '0;
         hold_high_q <= '0;
         fall_seen_q <= 1'b0;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!iEn) begin
            // Abort: partial counts are simply abandoned; ARM reloads them.
            state_q     <= ST_IDLE;
            fall_seen_q <= 1'b0;
            timeout_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: state_q <= ST_ARM;

               ST_ARM: begin
                  if (rise) begin
                     pcnt_q      <= CNT_ONE;
                     hcnt_q      <= CNT_ONE;
                     fall_seen_q <= 1'b0;
                     state_q     <= ST_MEASURE;
                  end
               end

               ST_MEASURE: begin
                  if (rise) begin
                     // A rise without a preceding fall cannot come from a
                     // clean signal: drop that period but keep measuring.
                     if (fall_seen_q) begin
                        period_q  <= pcnt_q;
                        high_q    <= hold_high_q;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                     end
                     pcnt_q      <= CNT_ONE;
                     hcnt_q      <= CNT_ONE;
                     fall_seen_q <= 1'b0;
                  end else if (pcnt_q == CNT_MAX) begin
                     // Saturate instead of wrapping; rearm for a fresh edge.
                     timeout_q <= 1'b1;
                     state_q   <= ST_ARM;
                  end else begin
                     pcnt_q <= pcnt_q + CNT_ONE;
                     if (!fall_seen_q) begin
                        if (fall) begin
                           hold_high_q <= hcnt_q;
                           fall_seen_q <= 1'b1;
                        end else begin
                           hcnt_q <= hcnt_q + CNT_ONE;
                        end
                     end
                  end
               end

               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign ovPeriod = period_q;
   assign ovHigh   = high_q;
   assign oValid   = valid_q;
   assign oTimeout = timeout_q;

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
// Scoreboard bench: each test pushes the results its stimulus should produce
// and pops them against what the output monitor captured on every oValid.
// Two instances share iRst and iSig: a 16-bit meter and a 4-bit meter used
// for the counter-saturation case.
module tb_clk_period_meter;

   typedef struct {
      int period;
      int high;
      int at;
      int nrise;
      bit tmo;
   } obs_t;

   typedef struct {
      int period;
      int high;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        en4;
   logic        sig;
   logic [15:0] period;
   logic [15:0] high;
   logic        valid;
   logic        tmo;
   logic [3:0]  period4;
   logic [3:0]  high4;
   logic        valid4;
   logic        tmo4;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   obs_t obs_q[$];
   obs_t obs4_q[$];
   exp_t exp_q[$];
   exp_t exp4_q[$];

   // generator controls (written by tests) and state (written by generator)
   int   gen_p  = 2;
   int   gen_h  = 1;
   int   gen_n  = 0;
   bit   gen_on = 1'b0;
   int   gen_cnt;
   int   ph;
   int   rises     = 0;
   int   last_rise = 0;

   always #5 clk = ~clk;

   clk_period_meter #(.CNT_BITS(16)) dut (
      .iClk     (clk),
      .iRst     (rst_n),
      .iEn      (en),
      .iSig     (sig),
      .ovPeriod (period),
      .ovHigh   (high),
      .oValid   (valid),
      .oTimeout (tmo)
   );

   clk_period_meter #(.CNT_BITS(4)) dut4 (
      .iClk     (clk),
      .iRst     (rst_n),
      .iEn      (en4),
      .iSig     (sig),
      .ovPeriod (period4),
      .ovHigh   (high4),
      .oValid   (valid4),
      .oTimeout (tmo4)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: record every result with its cycle and rise count.
   always @(negedge clk) begin
      if (valid)
         obs_q.push_back('{int'(period), int'(high), cyc, rises, tmo});
      if (valid4)
         obs4_q.push_back('{int'(period4), int'(high4), cyc, rises, tmo4});
   end

   // Pattern generator: gen_h cycles high, gen_p-gen_h low, at most gen_n
   // rises per enable of gen_on; changes land 2 time units after posedge.
   initial begin
      sig     = 1'b0;
      ph      = 0;
      gen_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (gen_on && (ph != 0 || gen_cnt < gen_n)) begin
            if (ph == 0) begin
               gen_cnt   = gen_cnt + 1;
               rises     = rises + 1;
               last_rise = cyc;
            end
            sig = (ph < gen_h);
            ph  = (ph + 1 >= gen_p) ? 0 : ph + 1;
         end else begin
            sig = 1'b0;
            ph  = 0;
            if (!gen_on) gen_cnt = 0;
         end
      end
   end

   task automatic wait_count(input bit four, input int n, input int budget,
                             output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((four ? obs4_q.size() : obs_q.size()) >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      en4   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (period !== 16'd0) begin
         n_err++; $display("FAIL reset_period: got %0d want 0", period);
      end
      n_cmp++;
      if (high !== 16'd0) begin
         n_err++; $display("FAIL reset_high: got %0d want 0", high);
      end
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b want 0", valid);
      end
      n_cmp++;
      if (tmo !== 1'b0 || tmo4 !== 1'b0) begin
         n_err++; $display("FAIL reset_timeout: got %b/%b want 0/0", tmo, tmo4);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      $display("reset: outputs cleared");
   endtask

   task automatic test_periodic(input int p, input int h, input int n);
      obs_t o;
      exp_t e;
      bit   ok;
      int   base;
      int   prev_at;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++; $display("FAIL stray_valid_p%0d: got %0d results want 0", p, obs_q.size());
      end
      obs_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back('{p, h});
      @(posedge clk);
      #1;
      en     = 1'b1;
      base   = rises;
      gen_p  = p;
      gen_h  = h;
      gen_n  = n + 1;
      gen_on = 1'b1;
      wait_count(1'b0, n, n * p + 60, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL count_p%0d: got %0d results want %0d", p, obs_q.size(), n);
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != n) begin
         n_err++; $display("FAIL extra_p%0d: got %0d results want %0d", p, obs_q.size(), n);
      end
      gen_on  = 1'b0;
      en      = 1'b0;
      prev_at = 0;
      for (int i = 0; i < n && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         $display("p=%0d h=%0d #%0d: period=%0d high=%0d at cycle %0d", p, h, i, o.period, o.high, o.at);
         n_cmp++;
         if (o.period !== e.period) begin
            n_err++; $display("FAIL period_p%0d[%0d]: got %0d want %0d", p, i, o.period, e.period);
         end
         n_cmp++;
         if (o.high !== e.high) begin
            n_err++; $display("FAIL high_p%0d[%0d]: got %0d want %0d", p, i, o.high, e.high);
         end
         if (i == 0 && p >= 6) begin
            n_cmp++;
            if (o.nrise - base != 2) begin
               n_err++; $display("FAIL first_rise_p%0d: got %0d rises want 2", p, o.nrise - base);
            end
         end
         if (i > 0) begin
            n_cmp++;
            if (o.at - prev_at != p) begin
               n_err++; $display("FAIL interval_p%0d[%0d]: got %0d want %0d", p, i, o.at - prev_at, p);
            end
         end
         prev_at = o.at;
      end
      exp_q.delete();
      obs_q.delete();
      repeat (3) @(posedge clk);
   endtask

   task automatic test_abort();
      obs_t o;
      exp_t e;
      bit   ok;
      int   rb;
      exp_q.push_back('{16, 8});
      @(posedge clk);
      #1;
      en     = 1'b1;
      gen_p  = 16;
      gen_h  = 8;
      gen_n  = 1000000;
      gen_on = 1'b1;
      wait_count(1'b0, 1, 80, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL abort_pre_timeout: got no result want 1");
      end
      if (obs_q.size() > 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.period !== e.period) begin
         n_err++; $display("FAIL abort_pre_period: got %0d want %0d", o.period, e.period);
      end
      // drop enable in the middle of the next period
      @(posedge clk);
      #1 en = 1'b0;
      repeat (4) @(posedge clk);
      #1 en = 1'b1;
      rb = rises;
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++; $display("FAIL abort_valid: got %0d results during abort want 0", obs_q.size());
      end
      obs_q.delete();
      exp_q.push_back('{16, 8});
      wait_count(1'b0, 1, 80, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL abort_post_timeout: got no result want 1");
      end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         $display("abort: resumed period=%0d high=%0d after %0d rises", o.period, o.high, o.nrise - rb);
         n_cmp++;
         if (o.nrise - rb != 2) begin
            n_err++; $display("FAIL abort_rises: got %0d want 2", o.nrise - rb);
         end
         n_cmp++;
         if (o.period !== e.period || o.high !== e.high) begin
            n_err++; $display("FAIL abort_result: got %0d/%0d want %0d/%0d", o.period, o.high, e.period, e.high);
         end
      end
      gen_on = 1'b0;
      en     = 1'b0;
      exp_q.delete();
      obs_q.delete();
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      obs_t o;
      exp_t e;
      bit   ok;
      int   rb;
      exp_q.push_back('{16, 8});
      @(posedge clk);
      #1;
      en     = 1'b1;
      gen_p  = 16;
      gen_h  = 8;
      gen_n  = 1000000;
      gen_on = 1'b1;
      wait_count(1'b0, 1, 80, ok);
      n_cmp++;
      if (!ok || obs_q.size() == 0) begin
         n_err++; $display("FAIL rstmid_pre: got no result want 1");
      end else begin
         o = obs_q.pop_front();
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (o.period !== e.period) begin
         n_err++; $display("FAIL rstmid_pre_period: got %0d want %0d", o.period, e.period);
      end
      // asynchronous reset pulse during the low phase, away from any edge
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (period !== 16'd0 || high !== 16'd0 || valid !== 1'b0 || tmo !== 1'b0) begin
         n_err++; $display("FAIL rstmid_clear: got %0d/%0d/%b/%b want 0/0/0/0", period, high, valid, tmo);
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rb = rises;
      obs_q.delete();
      exp_q.push_back('{16, 8});
      wait_count(1'b0, 1, 80, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL rstmid_post_timeout: got no result want 1");
      end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         $display("reset mid: resumed period=%0d high=%0d after %0d rises", o.period, o.high, o.nrise - rb);
         n_cmp++;
         if (o.nrise - rb != 2) begin
            n_err++; $display("FAIL rstmid_rises: got %0d want 2", o.nrise - rb);
         end
         n_cmp++;
         if (o.period !== e.period || o.high !== e.high) begin
            n_err++; $display("FAIL rstmid_result: got %0d/%0d want %0d/%0d", o.period, o.high, e.period, e.high);
         end
      end
      gen_on = 1'b0;
      en     = 1'b0;
      exp_q.delete();
      obs_q.delete();
      repeat (4) @(posedge clk);
   endtask

   task automatic test_timeout();
      obs_t o;
      exp_t e;
      bit   ok;
      obs4_q.delete();
      exp4_q.push_back('{6, 3});
      @(posedge clk);
      #1;
      en4    = 1'b1;
      gen_p  = 6;
      gen_h  = 3;
      gen_n  = 2;
      gen_on = 1'b1;
      wait_count(1'b1, 1, 60, ok);
      n_cmp++;
      if (!ok || obs4_q.size() == 0) begin
         n_err++; $display("FAIL tmo_first: got no result want 1");
      end else begin
         o = obs4_q.pop_front();
         e = exp4_q.pop_front();
         $display("timeout: first period=%0d high=%0d", o.period, o.high);
         n_cmp++;
         if (o.period !== e.period || o.high !== e.high) begin
            n_err++; $display("FAIL tmo_first_result: got %0d/%0d want %0d/%0d", o.period, o.high, e.period, e.high);
         end
      end
      // iSig now stays low; the 4-bit counter saturates at 15
      for (int i = 0; i < 40 && cyc < last_rise + 12; i++) @(negedge clk);
      n_cmp++;
      if (tmo4 !== 1'b0) begin
         n_err++; $display("FAIL tmo_early: got %b want 0", tmo4);
      end
      for (int i = 0; i < 30 && tmo4 !== 1'b1; i++) @(negedge clk);
      $display("timeout: flag=%b %0d cycles after last rise", tmo4, cyc - last_rise);
      n_cmp++;
      if (tmo4 !== 1'b1) begin
         n_err++; $display("FAIL tmo_set: got %b want 1", tmo4);
      end
      n_cmp++;
      if (period4 !== 4'd6 || high4 !== 4'd3) begin
         n_err++; $display("FAIL tmo_hold: got %0d/%0d want 6/3", period4, high4);
      end
      n_cmp++;
      if (obs4_q.size() != 0) begin
         n_err++; $display("FAIL tmo_valid: got %0d results want 0", obs4_q.size());
      end
      gen_on = 1'b0;
      repeat (2) @(posedge clk);
      exp4_q.push_back('{6, 3});
      #1 gen_on = 1'b1;
      wait_count(1'b1, 1, 60, ok);
      n_cmp++;
      if (!ok || obs4_q.size() == 0) begin
         n_err++; $display("FAIL tmo_recover: got no result want 1");
      end else begin
         o = obs4_q.pop_front();
         e = exp4_q.pop_front();
         $display("timeout: recovered period=%0d high=%0d flag=%b", o.period, o.high, o.tmo);
         n_cmp++;
         if (o.period !== e.period || o.high !== e.high) begin
            n_err++; $display("FAIL tmo_recover_result: got %0d/%0d want %0d/%0d", o.period, o.high, e.period, e.high);
         end
         n_cmp++;
         if (o.tmo !== 1'b0) begin
            n_err++; $display("FAIL tmo_clear: got %b want 0", o.tmo);
         end
      end
      gen_on = 1'b0;
      en4    = 1'b0;
      exp4_q.delete();
      repeat (4) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_periodic(16, 8, 5);
      test_periodic(6, 3, 5);
      test_periodic(2, 1, 10);
      test_periodic(10, 3, 4);
      test_abort();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_clk_period_meter
